// File: rtl/pwm_compare_output.sv
// PWM compare stage: turns the sine lookup duty value into a single-bit PWM waveform.
// Compare and top are double-buffered in shadow registers that reload only at the
// period wrap, or continuously while the block is disabled. o_wrap strobes once per
// period so the upstream phase accumulator can step.
module pwm_compare_output #(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_compare,
  input  logic [WIDTH-1:0] i_top,
  output logic             o_pwm,
  output logic             o_wrap
);

  localparam logic [15:0] PreLast = 16'(PRESCALE - 1);

  logic [15:0]      r_pre;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_top;
  logic [WIDTH-1:0] r_compare;

  logic tick;
  logic at_top;

  // Tick fires on the last clock of each prescale group.
  assign tick   = (r_pre == PreLast);
  assign at_top = (r_count == r_top);

  // Prescaler, period counter, shadow reload and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pre     <= '0;
      r_count   <= '0;
      r_top     <= '1;
      r_compare <= '0;
      o_pwm     <= 1'b0;
      o_wrap    <= 1'b0;
    end else if (!i_enable) begin
      // Idle: keep shadows tracking the inputs so the first period uses fresh values.
      r_pre     <= '0;
      r_count   <= '0;
      r_top     <= i_top;
      r_compare <= i_compare;
      o_pwm     <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      if (tick) begin
        r_pre <= '0;
        if (at_top) begin
          r_count   <= '0;
          r_top     <= i_top;
          r_compare <= i_compare;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_pre <= r_pre + 16'd1;
      end
      o_wrap <= tick && at_top;
      o_pwm  <= (r_count < r_compare);
    end
  end

endmodule
